// File: rtl/aes_seq_pkg.sv
// Shared types and constants for the AES round sequencer.
// State encoding, key-size codes and default round counts.
package aes_seq_pkg;

    typedef enum logic [2:0] {
        IDLE,
        INIT,
        PHASE0,
        PHASE1,
        DONE
    } state_t;

    localparam logic [1:0] KS_128 = 2'b00;
    localparam logic [1:0] KS_192 = 2'b01;
    localparam logic [1:0] KS_256 = 2'b10;

    localparam int NR_128_DEF = 10;
    localparam int NR_192_DEF = 12;
    localparam int NR_256_DEF = 14;

endpackage

// File: rtl/aes_round_counter.sv
// Round counter: holds round, latched round count and direction,
// and derives the last-round flag and the round-key index.
module aes_round_counter
    import aes_seq_pkg::*;
#(
    parameter int ROUND_W = 4,
    parameter int NR_128  = NR_128_DEF,
    parameter int NR_192  = NR_192_DEF,
    parameter int NR_256  = NR_256_DEF
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               clear,
    input  logic               inc,
    input  logic               load,
    input  logic [1:0]         key_size,
    input  logic               decrypt,
    output logic [ROUND_W-1:0] round,
    output logic [ROUND_W-1:0] key_idx,
    output logic               last_round
);

    logic [ROUND_W-1:0] nr_q;
    logic [ROUND_W-1:0] nr_sel;
    logic               dec_q;

    // Reserved code 2'b11 falls back to the 128-bit round count
    always_comb begin
        nr_sel = ROUND_W'(NR_128);
        case (key_size)
            KS_192:  nr_sel = ROUND_W'(NR_192);
            KS_256:  nr_sel = ROUND_W'(NR_256);
            default: nr_sel = ROUND_W'(NR_128);
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            round <= '0;
            nr_q  <= ROUND_W'(NR_128);
            dec_q <= 1'b0;
        end else if (load) begin
            round <= '0;
            nr_q  <= nr_sel;
            dec_q <= decrypt;
        end else if (clear) begin
            round <= '0;
        end else if (inc) begin
            round <= round + 1'b1;
        end
    end

    assign last_round = (round == nr_q);
    assign key_idx    = dec_q ? (nr_q - round) : round;

endmodule

// File: rtl/aes_round_sequencer.sv
// AES-128/192/256 round sequencer with output handshake and abort.
// Optional key-schedule stall input enabled by AES_SEQ_KEY_STALL_EN.
module aes_round_sequencer
    import aes_seq_pkg::*;
#(
    parameter int ROUND_W = 4,
    parameter int NR_128  = NR_128_DEF,
    parameter int NR_192  = NR_192_DEF,
    parameter int NR_256  = NR_256_DEF
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [1:0]         key_size,
    input  logic               decrypt,
    input  logic               abort,
    input  logic               out_ready,
`ifdef AES_SEQ_KEY_STALL_EN
    input  logic               key_ready,
`endif
    output logic               ready_in,
    output logic               busy,
    output logic               load_state,
    output logic               phase,
    output logic               mix_en,
    output logic [ROUND_W-1:0] round,
    output logic [ROUND_W-1:0] key_idx,
    output logic               out_valid
);

    state_t state;
    state_t state_n;
    logic   clear;
    logic   inc;
    logic   load;
    logic   go;
    logic   last_round;

`ifdef AES_SEQ_KEY_STALL_EN
    assign go = key_ready;
`else
    assign go = 1'b1;
`endif

    aes_round_counter #(
        .ROUND_W (ROUND_W),
        .NR_128  (NR_128),
        .NR_192  (NR_192),
        .NR_256  (NR_256)
    ) u_cnt (
        .clk        (clk),
        .reset      (reset),
        .clear      (clear),
        .inc        (inc),
        .load       (load),
        .key_size   (key_size),
        .decrypt    (decrypt),
        .round      (round),
        .key_idx    (key_idx),
        .last_round (last_round)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n    = state;
        clear      = 1'b0;
        inc        = 1'b0;
        load       = 1'b0;
        ready_in   = 1'b0;
        busy       = 1'b0;
        load_state = 1'b0;
        phase      = 1'b0;
        mix_en     = 1'b0;
        out_valid  = 1'b0;
        unique case (state)
            IDLE: begin
                ready_in = 1'b1;
                if (start) begin
                    load    = 1'b1;
                    state_n = INIT;
                end
            end
            INIT: begin
                busy       = 1'b1;
                load_state = 1'b1;
                if (go) begin
                    inc     = 1'b1;
                    state_n = PHASE0;
                end
            end
            PHASE0: begin
                busy    = 1'b1;
                state_n = PHASE1;
            end
            PHASE1: begin
                busy   = 1'b1;
                phase  = 1'b1;
                mix_en = !last_round;
                if (go) begin
                    if (last_round) begin
                        state_n = DONE;
                    end else begin
                        inc     = 1'b1;
                        state_n = PHASE0;
                    end
                end
            end
            DONE: begin
                busy      = 1'b1;
                out_valid = 1'b1;
                ready_in  = out_ready;
                // Back-to-back: a new block is accepted straight from DONE
                if (out_ready && start) begin
                    load    = 1'b1;
                    state_n = INIT;
                end else if (out_ready) begin
                    clear   = 1'b1;
                    state_n = IDLE;
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase
        // Abort overrides every other transition
        if (abort) begin
            state_n = IDLE;
            clear   = 1'b1;
            inc     = 1'b0;
            load    = 1'b0;
        end
    end

endmodule

// File: tb/tb_aes_round_sequencer.sv
// Scoreboard bench for aes_round_sequencer: directed runs, per-cycle
// trace checks, and a monitor that checks each completed block.
module tb_aes_round_sequencer;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic [1:0] key_size;
    logic       decrypt;
    logic       abort;
    logic       out_ready;
`ifdef AES_SEQ_KEY_STALL_EN
    logic       key_ready;
`endif
    logic       ready_in;
    logic       busy;
    logic       load_state;
    logic       phase;
    logic       mix_en;
    logic [3:0] round;
    logic [3:0] key_idx;
    logic       out_valid;

    aes_round_sequencer dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .key_size   (key_size),
        .decrypt    (decrypt),
        .abort      (abort),
        .out_ready  (out_ready),
`ifdef AES_SEQ_KEY_STALL_EN
        .key_ready  (key_ready),
`endif
        .ready_in   (ready_in),
        .busy       (busy),
        .load_state (load_state),
        .phase      (phase),
        .mix_en     (mix_en),
        .round      (round),
        .key_idx    (key_idx),
        .out_valid  (out_valid)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    typedef struct {
        int nr;
        int kidx;
        int acc;
        int lat;
    } exp_t;

    exp_t q[$];
    exp_t e;
    int   errors = 0;
    int   checks = 0;
    bit   prev_v = 1'b0;

    task automatic chk(input string name, input int act, input int exp_v);
        checks++;
        if (act !== exp_v) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)",
                     name, act, exp_v, cyc);
        end
    endtask

    function automatic int pk(input logic ls, input logic ph,
                              input logic mx, input logic bs,
                              input logic ov, input logic rd,
                              input logic [3:0] r, input logic [3:0] k);
        return int'({ls, ph, mx, bs, ov, rd, r, k});
    endfunction

    function automatic int dut_pk();
        return pk(load_state, phase, mix_en, busy, out_valid,
                  ready_in, round, key_idx);
    endfunction

    task automatic push_exp(input int nr, input int kidx, input int lat);
        exp_t x;
        x.nr   = nr;
        x.kidx = kidx;
        x.acc  = cyc;
        x.lat  = lat;
        q.push_back(x);
    endtask

    // Drive start in IDLE; returns #1 after the accepting edge
    task automatic start_block(input logic [1:0] ks, input logic dec);
        @(posedge clk);
        #1;
        start    = 1'b1;
        key_size = ks;
        decrypt  = dec;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    // Checks INIT and every phase cycle, k = edges since accept
    task automatic trace(input int nr, input bit dec, input bit noise);
        int r;
        logic ls, ph, mx;
        for (int k = 0; k <= 2 * nr; k++) begin
            @(negedge clk);
            ls = (k == 0);
            ph = (k > 0) && (k % 2 == 0);
            r  = (k == 0) ? 0 : (k + 1) / 2;
            mx = ph && (r != nr);
            chk("trace", dut_pk(),
                pk(ls, ph, mx, 1'b1, 1'b0, 1'b0, 4'(r),
                   dec ? 4'(nr - r) : 4'(r)));
            if (noise && k == 5) begin
                start    = 1'b1;
                key_size = 2'b10;
                decrypt  = 1'b1;
            end
            if (noise && k == 7) begin
                start    = 1'b0;
                key_size = 2'b00;
                decrypt  = 1'b0;
            end
        end
    endtask

    always @(negedge clk) begin
        if (reset && out_valid && !prev_v) begin
            if (q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_valid: got 1 expected 0 (cycle %0d)",
                         cyc);
            end else begin
                e = q.pop_front();
                chk("done_round", int'(round), e.nr);
                chk("done_key_idx", int'(key_idx), e.kidx);
                chk("latency", cyc - e.acc, e.lat);
            end
        end
        prev_v = reset && out_valid;
    end

    initial begin
        reset     = 1'b0;
        start     = 1'b0;
        key_size  = 2'b00;
        decrypt   = 1'b0;
        abort     = 1'b0;
        out_ready = 1'b1;
`ifdef AES_SEQ_KEY_STALL_EN
        key_ready = 1'b1;
`endif
        #12;
        chk("reset_outputs", dut_pk(), pk(0, 0, 0, 0, 0, 1, 0, 0));
        @(negedge clk);
        reset = 1'b1;

        // AES-128 encrypt with ignored start pulses mid-run
        start_block(2'b00, 1'b0);
        push_exp(10, 10, 21);
        trace(10, 1'b0, 1'b1);
        repeat (3) @(negedge clk);
        chk("idle_after_enc", dut_pk(), pk(0, 0, 0, 0, 0, 1, 0, 0));

        // AES-256 decrypt
        start_block(2'b10, 1'b1);
        push_exp(14, 0, 29);
        trace(14, 1'b1, 1'b0);
        repeat (3) @(negedge clk);
        chk("idle_after_dec", dut_pk(), pk(0, 0, 0, 0, 0, 1, 0, 14));

        // Backpressure then back-to-back AES-192
        out_ready = 1'b0;
        start_block(2'b00, 1'b0);
        push_exp(10, 10, 21);
        trace(10, 1'b0, 1'b0);
        @(negedge clk);
        repeat (5) begin
            @(negedge clk);
            chk("bp_hold", dut_pk(), pk(0, 0, 0, 1, 1, 0, 10, 10));
        end
        out_ready = 1'b1;
        start     = 1'b1;
        key_size  = 2'b01;
        decrypt   = 1'b0;
        #1;
        chk("bp_ready_in", int'(ready_in), 1);
        @(posedge clk);
        #1;
        start = 1'b0;
        push_exp(12, 12, 25);
        trace(12, 1'b0, 1'b0);
        repeat (3) @(negedge clk);

        // Abort in PHASE0 of round 4
        start_block(2'b00, 1'b0);
        repeat (8) @(negedge clk);
        chk("pre_abort", dut_pk(), pk(0, 0, 0, 1, 0, 0, 4, 4));
        abort = 1'b1;
        @(negedge clk);
        chk("abort_idle", dut_pk(), pk(0, 0, 0, 0, 0, 1, 0, 0));
        abort = 1'b0;
        repeat (30) @(negedge clk);

        // Abort together with start in IDLE
        abort = 1'b1;
        start = 1'b1;
        @(negedge clk);
        chk("abort_start_idle", dut_pk(), pk(0, 0, 0, 0, 0, 1, 0, 0));
        abort = 1'b0;
        start = 1'b0;
        repeat (2) @(negedge clk);

        // Asynchronous reset during PHASE1 of a decrypt run
        start_block(2'b10, 1'b1);
        repeat (5) @(negedge clk);
        chk("pre_reset", dut_pk(), pk(0, 1, 1, 1, 0, 0, 2, 12));
        #2;
        reset = 1'b0;
        #1;
        chk("async_reset", dut_pk(), pk(0, 0, 0, 0, 0, 1, 0, 0));
        @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);

`ifdef AES_SEQ_KEY_STALL_EN
        // Key stall for three cycles in PHASE1 of round 2
        start_block(2'b00, 1'b0);
        push_exp(10, 10, 24);
        repeat (5) @(negedge clk);
        key_ready = 1'b0;
        repeat (3) begin
            @(negedge clk);
            chk("stall_hold", dut_pk(), pk(0, 1, 1, 1, 0, 0, 2, 2));
        end
        key_ready = 1'b1;
        repeat (25) @(negedge clk);
`endif

        repeat (5) @(negedge clk);
        chk("queue_empty", q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
